// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: gathers a DEPTH-sample frame from the ADC reader,
// then streams it word-by-word through the SPI master TX handshake.
module adc_frame_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_DV,
    input  logic              i_TX_Ready,
    output logic [DATA_W-1:0] o_TX_Byte,
    output logic              o_TX_DV,
    output logic              o_Frame_Start,
    output logic              o_Busy,
    output logic [7:0]        o_Drop_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Sample storage: written only while a frame is being collected
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L && state == FILL && i_DV) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    // Count samples that arrive while the frame is draining; saturates
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Drop_Count <= 8'd0;
        end else if (i_DV && state != FILL && o_Drop_Count != 8'hFF) begin
            o_Drop_Count <= o_Drop_Count + 8'd1;
        end
    end

    // Frame sequencer with registered strobes and busy flag
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state         <= FILL;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_TX_Byte     <= '0;
            o_TX_DV       <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_TX_DV       <= 1'b0;
            o_Frame_Start <= 1'b0;
            unique case (state)
                FILL: begin
                    if (i_DV) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr == LAST) begin
                            rd_ptr <= '0;
                            state  <= ISSUE;
                            o_Busy <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (i_TX_Ready) begin
                        o_TX_Byte     <= mem[rd_ptr];
                        o_TX_DV       <= 1'b1;
                        o_Frame_Start <= (rd_ptr == '0);
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!i_TX_Ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_TX_Ready) begin
                        if (rd_ptr == LAST) begin
                            rd_ptr <= '0;
                            state  <= FILL;
                            o_Busy <= 1'b0;
                        end else begin
                            rd_ptr <= rd_ptr + ONE;
                            state  <= ISSUE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: scoreboard bench with a frame-level reference
// model and a simple SPI master responder.
module tb_adc_frame_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] data    = '0;
    logic          dv      = 1'b0;
    logic          ready   = 1'b1;
    logic [DW-1:0] tx_byte;
    logic          tx_dv;
    logic          fs;
    logic          busy;
    logic [7:0]    drop_cnt;

    adc_frame_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Data       (data),
        .i_DV         (dv),
        .i_TX_Ready   (ready),
        .o_TX_Byte    (tx_byte),
        .o_TX_DV      (tx_dv),
        .o_Frame_Start(fs),
        .o_Busy       (busy),
        .o_Drop_Count (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Reference model state: collected samples, expected strobes
    typedef struct {
        logic [DW-1:0] d;
        logic          first;
        int            due;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] frame[$];
    bit            filling   = 1'b1;
    int            drops     = 0;
    int            word      = 0;
    int            xfer      = 0;
    int            cyc       = 0;
    int            strobes   = 0;
    logic [DW-1:0] last_byte = '0;

    // SPI responder controls
    bit spi_forced = 1'b0;
    bit forced_val = 1'b1;
    int spi_busy   = 20;
    int busy_cnt   = 0;

    task automatic model_step();
        bit   was_filling;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            filling   = 1'b1;
            frame.delete();
            expq.delete();
            drops     = 0;
            word      = 0;
            xfer      = 0;
            last_byte = '0;
            return;
        end
        was_filling = filling;
        if (dv) begin
            if (was_filling) begin
                frame.push_back(data);
                if (frame.size() == DEPTH) begin
                    filling = 1'b0;
                    word    = 0;
                    xfer    = 0;
                end
            end else if (drops < 255) begin
                drops++;
            end
        end
        if (!was_filling) begin
            // xfer: 0 offer word, 1 await take, 2 await master idle
            case (xfer)
                0: if (ready) begin
                    e.d     = frame[word];
                    e.first = (word == 0);
                    e.due   = cyc;
                    expq.push_back(e);
                    xfer    = 1;
                end
                1: if (!ready) xfer = 2;
                default: if (ready) begin
                    word++;
                    if (word == DEPTH) begin
                        filling = 1'b1;
                        frame.delete();
                    end else begin
                        xfer = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (tx_dv) begin
            strobes++;
            if (expq.size() == 0) begin
                chk("spurious_strobe", 1, 0);
                last_byte = tx_byte;
            end else begin
                e = expq.pop_front();
                chk("tx_byte", 32'(tx_byte), 32'(e.d));
                chk("frame_start", 32'(fs), 32'(e.first));
                chk("strobe_cycle", cyc, e.due);
                last_byte = e.d;
            end
        end else begin
            if (fs) chk("lone_frame_start", 1, 0);
            if (expq.size() > 0 && expq[0].due <= cyc) begin
                chk("missed_strobe", cyc, expq[0].due);
                void'(expq.pop_front());
            end
            chk("tx_byte_hold", 32'(tx_byte), 32'(last_byte));
        end
        chk("busy", 32'(busy), 32'(!filling));
        chk("drop_count", 32'(drop_cnt), drops);
    endtask

    task automatic spi_step();
        if (!rst_n) begin
            busy_cnt = 0;
            ready    = 1'b1;
        end else if (spi_forced) begin
            ready = forced_val;
        end else if (tx_dv) begin
            busy_cnt = spi_busy;
            ready    = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) ready = 1'b1;
        end else begin
            ready = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            monitor_step();
            spi_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_seq(input logic [DW-1:0] base, input int n,
                            input int gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv   = 1'b1;
            data = rnd ? DW'($urandom) : base + DW'(i);
            if (gap > 0) begin
                @(negedge clk);
                dv = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (!(filling && expq.size() == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("drain_timeout", n, 0);
        tick(2);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        tick(n);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_fs", 32'(fs), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drops", 32'(drop_cnt), 0);
        chk("rst_byte", 32'(tx_byte), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        int n;
        tick(3);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_fs", 32'(fs), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drops", 32'(drop_cnt), 0);
        chk("rst_byte", 32'(tx_byte), 0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_tx_dv", 32'(tx_dv), 0);

        // Single frame, slow samples, 20-cycle SPI busy
        spi_busy = 20;
        s0 = strobes;
        send_seq(16'h0001, 8, 10, 1'b0);
        wait_drain(2000);
        chk("single_strobes", strobes - s0, 8);

        // Random frames, random pacing and SPI speed
        for (int f = 0; f < 5; f++) begin
            spi_busy = $urandom_range(1, 30);
            send_seq('0, 8 + $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
            wait_drain(3000);
        end

        // Overrun: 12 back-to-back samples while SPI is slow
        do_reset(2);
        spi_busy = 40;
        s0 = strobes;
        send_seq(16'h0001, 12, 0, 1'b0);
        chk("overrun_drops", 32'(drop_cnt), 4);
        wait_drain(3000);
        send_seq(16'h000D, 8, 1, 1'b0);
        wait_drain(3000);
        chk("overrun_strobes", strobes - s0, 16);

        // Handshake stall: ready never drops after first strobe
        spi_forced = 1'b1;
        forced_val = 1'b1;
        s0 = strobes;
        send_seq(16'h0001, 8, 0, 1'b0);
        tick(40);
        chk("stall_one_strobe", strobes - s0, 1);
        chk("stall_busy", 32'(busy), 1);
        forced_val = 1'b0;
        tick(2);
        forced_val = 1'b1;
        tick(5);
        chk("stall_second", strobes - s0, 2);
        forced_val = 1'b0;
        tick(2);
        spi_forced = 1'b0;
        wait_drain(2000);
        chk("stall_total", strobes - s0, 8);

        // Saturation: master stuck busy, 300 extra samples
        do_reset(2);
        spi_forced = 1'b1;
        forced_val = 1'b0;
        send_seq('0, 8, 0, 1'b1);
        s0 = strobes;
        send_seq('0, 300, 1, 1'b1);
        chk("sat_drops", 32'(drop_cnt), 255);
        chk("sat_no_strobe", strobes - s0, 0);
        do_reset(2);
        spi_forced = 1'b0;

        // Reset mid-drain, then a fresh frame
        spi_busy = 6;
        s0 = strobes;
        send_seq('0, 8, 0, 1'b1);
        n = 0;
        while (strobes - s0 < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("middrain_timeout", n, 0);
        do_reset(2);
        tick(3);
        s0 = strobes;
        send_seq(16'hA000, 8, 2, 1'b0);
        wait_drain(2000);
        chk("after_rst_strobes", strobes - s0, 8);

        tick(5);
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
